// File: rtl/ps2_rx_fifo_if.sv
// rtl/ps2_rx_fifo_if.sv - read-side and status bundle of the PS/2 receive FIFO
interface ps2_rx_fifo_if #(
    parameter int FIFO_AW = 4
);
    logic             rd_en;
    logic [7:0]       rd_data;
    logic             rd_ext;
    logic             rd_brk;
    logic             empty;
    logic             full;
    logic [FIFO_AW:0] count;
    logic             parity_error;
    logic             frame_error;
    logic             overflow;
    logic             clr_ovf;

    // Receiver side: answers pops and reports status.
    modport slave (
        input  rd_en, clr_ovf,
        output rd_data, rd_ext, rd_brk, empty, full, count,
               parity_error, frame_error, overflow
    );

    // Consumer side: drains codes and acknowledges overflow.
    modport master (
        output rd_en, clr_ovf,
        input  rd_data, rd_ext, rd_brk, empty, full, count,
               parity_error, frame_error, overflow
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 keyboard receiver with glitch filter, watchdog, prefix decode and FWFT FIFO
module ps2_rx_fifo #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_AW        = 4,
    parameter int DECODE         = 1
) (
    input  logic          sys_clk,
    input  logic          reset,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    ps2_rx_fifo_if.slave  rd_if
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int FCW   = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam int WDW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [FCW-1:0]     FILT_LAST = FCW'(FILTER_LEN - 1);
    localparam logic [WDW-1:0]     WD_LAST   = WDW'(TIMEOUT_CYCLES - 1);
    localparam logic [FIFO_AW:0]   CNT_FULL  = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    logic               r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic               r_clk_f, r_clk_fd;
    logic [FCW-1:0]     r_flt_cnt;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_bit_cnt;
    logic [9:0]         r_shift;
    logic [WDW-1:0]     r_wdog;
    logic               r_ext_pend, r_brk_pend;
    logic               r_parity_error, r_frame_error, r_overflow;
    logic [9:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [FIFO_AW:0]   r_count;

    logic               w_fall, w_data;
    logic               w_timeout, w_in_check, w_par_bad, w_stop_bad, w_good;
    logic               w_is_prefix, w_push, w_pop, w_do_push, w_ovf_event;
    logic               w_empty, w_full;
    logic [9:0]         w_head;

    // Two-flop synchronisers; idle bus level is high.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // Filtered clock follows the synchronised clock only after FILTER_LEN differing samples in a row.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            r_clk_f   <= 1'b1;
            r_clk_fd  <= 1'b1;
            r_flt_cnt <= '0;
        end else begin
            r_clk_fd <= r_clk_f;
            if (r_clk_s2 != r_clk_f) begin
                if (r_flt_cnt == FILT_LAST) begin
                    r_clk_f   <= r_clk_s2;
                    r_flt_cnt <= '0;
                end else begin
                    r_flt_cnt <= r_flt_cnt + FCW'(1);
                end
            end else begin
                r_flt_cnt <= '0;
            end
        end
    end

    assign w_fall = r_clk_fd & ~r_clk_f;
    assign w_data = r_dat_s2;

    // State register.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state plus frame verdicts and decode decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        w_in_check  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall && !w_data) w_state_nxt = S_RECV;
            end
            S_RECV: begin
                if (w_fall) begin
                    if (r_bit_cnt == 4'd9) w_state_nxt = S_CHECK;
                end else if (r_wdog == WD_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_CHECK: begin
                w_in_check  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Odd parity: data bits plus parity bit must XOR to 1; parity beats stop bit.
        w_par_bad   = w_in_check & ~(^r_shift[8:0]);
        w_stop_bad  = w_in_check & (^r_shift[8:0]) & ~r_shift[9];
        w_good      = w_in_check & (^r_shift[8:0]) & r_shift[9];
        w_is_prefix = (DECODE != 0) && ((r_shift[7:0] == 8'hE0) || (r_shift[7:0] == 8'hF0));
        w_push      = w_good & ~w_is_prefix;
    end

    // Bit counter, LSB-first shifter and inactivity watchdog.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_wdog    <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_fall && !w_data) begin
                r_bit_cnt <= '0;
                r_wdog    <= '0;
            end
        end else if (r_state == S_RECV) begin
            if (w_fall) begin
                r_shift   <= {w_data, r_shift[9:1]};
                r_bit_cnt <= r_bit_cnt + 4'd1;
                r_wdog    <= '0;
            end else begin
                r_wdog <= r_wdog + WDW'(1);
            end
        end
    end

    // Prefix flags: set by E0/F0, cleared by a pushed code or any aborted/bad frame.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
        end else if (w_timeout || w_par_bad || w_stop_bad || w_push) begin
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
        end else if (w_good && w_is_prefix) begin
            if (r_shift[7:0] == 8'hE0) r_ext_pend <= 1'b1;
            else                       r_brk_pend <= 1'b1;
        end
    end

    // Registered one-cycle error strobes.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            r_parity_error <= 1'b0;
            r_frame_error  <= 1'b0;
        end else begin
            r_parity_error <= w_par_bad;
            r_frame_error  <= w_stop_bad | w_timeout;
        end
    end

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CNT_FULL);
    assign w_pop       = rd_if.rd_en & ~w_empty;
    assign w_do_push   = w_push & (~w_full | w_pop);
    assign w_ovf_event = w_push & w_full & ~w_pop;

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge sys_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= {r_ext_pend, r_brk_pend, r_shift[7:0]};
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            if (w_do_push && !w_pop)      r_count <= r_count + (FIFO_AW + 1)'(1);
            else if (w_pop && !w_do_push) r_count <= r_count - (FIFO_AW + 1)'(1);
        end
    end

    // Sticky overflow; a new drop outranks a simultaneous clear.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset)              r_overflow <= 1'b0;
        else if (w_ovf_event)    r_overflow <= 1'b1;
        else if (rd_if.clr_ovf)  r_overflow <= 1'b0;
    end

    assign w_head             = r_mem[r_rd_ptr];
    assign rd_if.rd_data      = w_empty ? 8'h00 : w_head[7:0];
    assign rd_if.rd_ext       = w_empty ? 1'b0  : w_head[9];
    assign rd_if.rd_brk       = w_empty ? 1'b0  : w_head[8];
    assign rd_if.empty        = w_empty;
    assign rd_if.full         = w_full;
    assign rd_if.count        = r_count;
    assign rd_if.parity_error = r_parity_error;
    assign rd_if.frame_error  = r_frame_error;
    assign rd_if.overflow     = r_overflow;
endmodule
